// File: rtl/annul_reduce_pipeline_if.sv
// Handshake bundle for annul_reduce_pipeline: input beat (valid/ready/select/data) and
// reduced output beat (valid/ready/data/none/conflict).
interface annul_reduce_pipeline_if #(
    parameter int WORD_WIDTH = 8,
    parameter int CHANNELS   = 4
);
    logic                           in_valid;
    logic                           in_ready;
    logic [CHANNELS-1:0]            in_select;
    logic [CHANNELS*WORD_WIDTH-1:0] in_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [WORD_WIDTH-1:0]          out_data;
    logic                           out_none;
    logic                           out_conflict;

    // Producer/consumer side: drives beats in and accepts results.
    modport master (
        output in_valid, in_select, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_none, out_conflict
    );

    // Pipeline side.
    modport slave (
        input  in_valid, in_select, in_data, out_ready,
        output in_ready, out_valid, out_data, out_none, out_conflict
    );
endinterface

// File: rtl/annul_reduce_pipeline.sv
// Two-stage annul-then-reduce pipeline with stall backpressure. Optional macro
// ANNUL_REDUCE_PIPELINE_CONFLICT_EN adds a registered ">1 channel selected" flag.
module annul_reduce_pipeline #(
    parameter int    WORD_WIDTH  = 8,
    parameter int    CHANNELS    = 4,
    parameter string REDUCE_MODE = "OR"
) (
    input  logic                      clock,
    input  logic                      clear_n,
    annul_reduce_pipeline_if.slave    bus
);
    localparam bit IS_OR  = (REDUCE_MODE == "OR");
    localparam bit IS_AND = (REDUCE_MODE == "AND");
    localparam bit IS_XOR = (REDUCE_MODE == "XOR");

    if (!(IS_OR || IS_AND || IS_XOR)) begin : g_bad_mode
        $error("annul_reduce_pipeline: REDUCE_MODE must be \"OR\", \"AND\" or \"XOR\"");
    end

    typedef logic [WORD_WIDTH-1:0] word_t;

    // Annulled channels become the identity of the reduction so they drop out of it.
    localparam word_t IDENTITY = {WORD_WIDTH{IS_AND}};

    logic  advance;
    logic  s1_valid_q, s1_valid_d;
    logic  s1_none_q,  s1_none_d;
    word_t s1_word_q [CHANNELS];
    word_t s1_word_d [CHANNELS];
    logic  out_valid_q, out_valid_d;
    logic  out_none_q,  out_none_d;
    word_t out_data_q,  out_data_d;
    word_t reduced;

    assign advance      = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = advance;

    always_comb begin
        reduced = IDENTITY;
        for (int i = 0; i < CHANNELS; i++) begin
            if (IS_AND)      reduced = reduced & s1_word_q[i];
            else if (IS_XOR) reduced = reduced ^ s1_word_q[i];
            else             reduced = reduced | s1_word_q[i];
        end
    end

    // NOTE: every always_comb output gets a hold default first, so no path leaves it unassigned (no latch).
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_none_d   = s1_none_q;
        out_valid_d = out_valid_q;
        out_none_d  = out_none_q;
        out_data_d  = out_data_q;
        for (int i = 0; i < CHANNELS; i++) begin
            s1_word_d[i] = s1_word_q[i];
        end
        if (advance) begin
            s1_valid_d = bus.in_valid;
            s1_none_d  = ~|bus.in_select;
            for (int i = 0; i < CHANNELS; i++) begin
                s1_word_d[i] = bus.in_select[i] ? bus.in_data[i*WORD_WIDTH +: WORD_WIDTH] : IDENTITY;
            end
            out_valid_d = s1_valid_q;
            out_none_d  = s1_none_q;
            // AND with nothing selected would give all-ones; an empty selection always reports zero.
            out_data_d  = s1_none_q ? '0 : reduced;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            s1_valid_q  <= 1'b0;
            s1_none_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_none_q  <= 1'b0;
            out_data_q  <= '0;
            // NOTE: the stage word array is a small register bank, not RAM, so clearing it on reset is cheap and intended.
            for (int i = 0; i < CHANNELS; i++) begin
                s1_word_q[i] <= '0;
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_none_q   <= s1_none_d;
            out_valid_q <= out_valid_d;
            out_none_q  <= out_none_d;
            out_data_q  <= out_data_d;
            for (int i = 0; i < CHANNELS; i++) begin
                s1_word_q[i] <= s1_word_d[i];
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_none  = out_none_q;

`ifdef ANNUL_REDUCE_PIPELINE_CONFLICT_EN
    logic s1_conflict_q,  s1_conflict_d;
    logic out_conflict_q, out_conflict_d;

    always_comb begin
        s1_conflict_d  = s1_conflict_q;
        out_conflict_d = out_conflict_q;
        if (advance) begin
            s1_conflict_d  = ($countones(bus.in_select) > 1);
            out_conflict_d = s1_conflict_q;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            s1_conflict_q  <= 1'b0;
            out_conflict_q <= 1'b0;
        end else begin
            s1_conflict_q  <= s1_conflict_d;
            out_conflict_q <= out_conflict_d;
        end
    end

    assign bus.out_conflict = out_conflict_q;
`else
    assign bus.out_conflict = 1'b0;
`endif
endmodule

// File: tb/tb_annul_reduce_pipeline.sv
// Scoreboard bench: OR, AND and XOR instances share one stimulus stream; expected
// results are queued on input transfer and compared on output transfer.
module tb_annul_reduce_pipeline;
    localparam int W  = 8;
    localparam int CH = 4;
`ifdef ANNUL_REDUCE_PIPELINE_CONFLICT_EN
    localparam bit CONFLICT_EN = 1'b1;
`else
    localparam bit CONFLICT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] data;
        logic         none;
        logic         conflict;
    } exp_t;
    typedef exp_t [2:0] exp3_t;

    logic            clk = 1'b0;
    logic            clear_n;
    logic            in_valid;
    logic [CH-1:0]   in_select;
    logic [CH*W-1:0] in_data;
    logic            out_ready;

    int    n_compared   = 0;
    int    n_mismatched = 0;
    exp3_t sb [$];

    always #5 clk = ~clk;

    annul_reduce_pipeline_if #(.WORD_WIDTH(W), .CHANNELS(CH)) if_or  ();
    annul_reduce_pipeline_if #(.WORD_WIDTH(W), .CHANNELS(CH)) if_and ();
    annul_reduce_pipeline_if #(.WORD_WIDTH(W), .CHANNELS(CH)) if_xor ();

    assign if_or.in_valid   = in_valid;   assign if_and.in_valid  = in_valid;   assign if_xor.in_valid  = in_valid;
    assign if_or.in_select  = in_select;  assign if_and.in_select = in_select;  assign if_xor.in_select = in_select;
    assign if_or.in_data    = in_data;    assign if_and.in_data   = in_data;    assign if_xor.in_data   = in_data;
    assign if_or.out_ready  = out_ready;  assign if_and.out_ready = out_ready;  assign if_xor.out_ready = out_ready;

    annul_reduce_pipeline #(.WORD_WIDTH(W), .CHANNELS(CH), .REDUCE_MODE("OR"))
        u_or  (.clock(clk), .clear_n(clear_n), .bus(if_or.slave));
    annul_reduce_pipeline #(.WORD_WIDTH(W), .CHANNELS(CH), .REDUCE_MODE("AND"))
        u_and (.clock(clk), .clear_n(clear_n), .bus(if_and.slave));
    annul_reduce_pipeline #(.WORD_WIDTH(W), .CHANNELS(CH), .REDUCE_MODE("XOR"))
        u_xor (.clock(clk), .clear_n(clear_n), .bus(if_xor.slave));

    logic         ov [3];
    logic         ir [3];
    logic [W-1:0] od [3];
    logic         on [3];
    logic         oc [3];
    assign ov[0] = if_or.out_valid;    assign ov[1] = if_and.out_valid;    assign ov[2] = if_xor.out_valid;
    assign ir[0] = if_or.in_ready;     assign ir[1] = if_and.in_ready;     assign ir[2] = if_xor.in_ready;
    assign od[0] = if_or.out_data;     assign od[1] = if_and.out_data;     assign od[2] = if_xor.out_data;
    assign on[0] = if_or.out_none;     assign on[1] = if_and.out_none;     assign on[2] = if_xor.out_none;
    assign oc[0] = if_or.out_conflict; assign oc[1] = if_and.out_conflict; assign oc[2] = if_xor.out_conflict;

    // Reference: fold only the selected channels (mode 0=OR, 1=AND, 2=XOR).
    function automatic exp_t model(int mode, logic [CH-1:0] sel, logic [CH*W-1:0] d);
        exp_t         e;
        logic [W-1:0] acc;
        logic [W-1:0] w;
        int           cnt;
        acc = '0;
        cnt = 0;
        for (int i = 0; i < CH; i++) begin
            if (sel[i]) begin
                w = d[i*W +: W];
                if (cnt == 0)      acc = w;
                else if (mode == 1) acc = acc & w;
                else if (mode == 2) acc = acc ^ w;
                else               acc = acc | w;
                cnt++;
            end
        end
        e.data     = acc;
        e.none     = (cnt == 0);
        e.conflict = CONFLICT_EN && (cnt > 1);
        return e;
    endfunction

    // One clock: sample mid-cycle at negedge, then move to just after the next rising edge.
    task automatic step();
        exp3_t e;
        @(negedge clk);
        if (in_valid && ir[0]) begin
            e[0] = model(0, in_select, in_data);
            e[1] = model(1, in_select, in_data);
            e[2] = model(2, in_select, in_data);
            sb.push_back(e);
        end
        if (ov[0] && out_ready) begin
            if (sb.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("FAIL sb_unexpected_beat: got data=%h with no beat outstanding", od[0]);
            end else begin
                e = sb.pop_front();
                for (int m = 0; m < 3; m++) begin
                    n_compared++;
                    if (!ov[m] || {od[m], on[m], oc[m]} !== e[m]) begin
                        n_mismatched++;
                        $display("FAIL sb_mode%0d: got v=%b data=%h none=%b conf=%b, want data=%h none=%b conf=%b",
                                 m, ov[m], od[m], on[m], oc[m], e[m].data, e[m].none, e[m].conflict);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CH-1:0] sel, input logic [CH*W-1:0] d, input logic rdy);
        in_valid  = v;
        in_select = sel;
        in_data   = d;
        out_ready = rdy;
    endtask

    task automatic drain();
        drive(1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        n_compared++;
        if (sb.size() != 0) begin
            n_mismatched++;
            $display("FAIL drain_timeout: %0d beats outstanding, want 0", sb.size());
        end
    endtask

    task automatic test_reset();
        clear_n = 1'b0;
        drive(1'b0, '0, '0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        for (int m = 0; m < 3; m++) begin
            n_compared++;
            if ({ov[m], od[m], on[m], oc[m], ir[m]} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
                n_mismatched++;
                $display("FAIL reset_mode%0d: got v=%b data=%h none=%b conf=%b rdy=%b, want 0/00/0/0/1",
                         m, ov[m], od[m], on[m], oc[m], ir[m]);
            end
        end
        clear_n = 1'b1;
        step();
    endtask

    task automatic test_latency();
        drive(1'b1, 4'b0100, 32'hDDCCBBAA, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b1);
        n_compared++;
        if (ov[0] !== 1'b0) begin
            n_mismatched++;
            $display("FAIL latency_edge1: out_valid=%b, want 0", ov[0]);
        end
        step();
        n_compared++;
        if ({ov[0], od[0], on[0], oc[0]} !== {1'b1, 8'hCC, 1'b0, 1'b0}) begin
            n_mismatched++;
            $display("FAIL latency_edge2: v=%b data=%h none=%b conf=%b, want 1/cc/0/0", ov[0], od[0], on[0], oc[0]);
        end
        drain();
    endtask

    task automatic test_patterns();
        logic [CH-1:0]   sels  [5] = '{4'b0011, 4'b0000, 4'b1001, 4'b1111, 4'b1000};
        logic [CH*W-1:0] datas [5] = '{32'hDDCCBBAA, 32'hDDCCBBAA, 32'hDDCCBBAA, 32'hF00FFF01, 32'h80000000};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, sels[i], datas[i], 1'b1);
            step();
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] held;
        for (int c = 0; c < 8; c++) begin
            drive(c < 3, 4'b0001 << c, 32'h11223344 + 32'h01010101 * c, !(c >= 3 && c <= 5));
            #1;
            if (c == 3) held = od[0];
            if (c >= 3 && c <= 5) begin
                n_compared++;
                if (ir[0] !== 1'b0 || ov[0] !== 1'b1 || od[0] !== held) begin
                    n_mismatched++;
                    $display("FAIL stall_c%0d: in_ready=%b v=%b data=%h, want 0/1/%h", c, ir[0], ov[0], od[0], held);
                end
            end
            step();
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            drive($urandom_range(3) != 0, CH'($urandom), $urandom, $urandom_range(3) != 0);
            step();
        end
        drain();
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 4'b0110, 32'h0F0F0F0F, 1'b1);
        step();
        drive(1'b1, 4'b1010, 32'hA5A5A5A5, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b1);
        #2;
        clear_n = 1'b0;
        #1;
        for (int m = 0; m < 3; m++) begin
            n_compared++;
            if (ov[m] !== 1'b0 || od[m] !== 8'h00) begin
                n_mismatched++;
                $display("FAIL midreset_mode%0d: v=%b data=%h, want 0/00", m, ov[m], od[m]);
            end
        end
        sb.delete();
        step();
        step();
        clear_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_compared++;
            if (ov[0] !== 1'b0) begin
                n_mismatched++;
                $display("FAIL stale_beat_%0d: out_valid=%b, want 0", i, ov[0]);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_patterns();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
